// File: rtl/lcd_spi_writer.sv
// Serialises one command/data byte MSB-first onto a 4-wire SPI LCD bus, then pulses wr_finish.
// All outputs are registered; rst aborts any transfer in progress without a wr_finish.
module lcd_spi_writer #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CE_SETUP = 2,
  parameter int unsigned CE_HOLD  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_enable,
  input  logic       wr_dc,
  input  logic [7:0] wr_data,
  output logic       wr_finish,
  output logic       busy,
  output logic       lcd_ce_n,
  output logic       lcd_dc,
  output logic       lcd_sclk,
  output logic       lcd_din
);

  typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, HOLD, DONE} state_t;

  // Counters are loaded with N-1 on state entry, so each state lasts exactly N cycles.
  localparam logic [7:0] SETUP_LD = 8'(CE_SETUP - 1);
  localparam logic [7:0] DIV_LD   = 8'(CLK_DIV - 1);
  localparam logic [7:0] HOLD_LD  = 8'(CE_HOLD - 1);

  state_t     state;
  logic [7:0] cnt;
  logic [2:0] bit_cnt;
  logic [6:0] shreg;  // bit 7 goes straight to lcd_din on accept

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      lcd_ce_n  <= 1'b1;
      lcd_sclk  <= 1'b0;
      lcd_din   <= 1'b0;
      lcd_dc    <= 1'b0;
      wr_finish <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_enable) begin
            shreg    <= wr_data[6:0];
            lcd_din  <= wr_data[7];
            lcd_dc   <= wr_dc;
            bit_cnt  <= 3'd7;
            lcd_ce_n <= 1'b0;
            busy     <= 1'b1;
            cnt      <= SETUP_LD;
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            cnt   <= DIV_LD;
            state <= LOW;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        LOW: begin
          if (cnt == '0) begin
            lcd_sclk <= 1'b1;
            cnt      <= DIV_LD;
            state    <= HIGH;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        HIGH: begin
          if (cnt == '0) begin
            lcd_sclk <= 1'b0;
            if (bit_cnt != '0) begin
              lcd_din <= shreg[6];
              shreg   <= {shreg[5:0], 1'b0};
              bit_cnt <= bit_cnt - 3'd1;
              cnt     <= DIV_LD;
              state   <= LOW;
            end else begin
              cnt   <= HOLD_LD;
              state <= HOLD;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            lcd_ce_n  <= 1'b1;
            wr_finish <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        DONE: begin
          wr_finish <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
